// File: rtl/trig_sched_pkg.sv
// trig_sched_pkg: shared types and constants for the trigger scheduler.
//   state_e  - scheduler FSM states
//   clog2    - width helper for counters and indices
//   *_DEF    - default NREQ / TIMEOUT / GAP values
package trig_sched_pkg;

    localparam int NREQ_DEF    = 4;
    localparam int TIMEOUT_DEF = 16;
    localparam int GAP_DEF     = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/trig_sched_if.sv
// trig_sched_if: requester / trigger-unit side signals of the scheduler.
//   req, trigger            - driven by the requesters and the trigger unit
//   ena, grant, done, err,
//   busy                    - driven by the scheduler
// master: requester/unit side; slave: scheduler side.
interface trig_sched_if
    import trig_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
);
    logic [NREQ-1:0] req;
    logic            trigger;
    logic            ena;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] done;
    logic [NREQ-1:0] err;
    logic            busy;

    modport master (
        output req, trigger,
        input  ena, grant, done, err, busy
    );

    modport slave (
        input  req, trigger,
        output ena, grant, done, err, busy
    );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req   - request vector
//   last  - index granted most recently; search starts at last+1
//   pick  - index of the winning requester
//   valid - at least one request is pending
module rr_arbiter
    import trig_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    localparam int IDXW = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] last,
    output logic [IDXW-1:0] pick,
    output logic            valid
);

    logic [NREQ-1:0] rot;
    logic [IDXW-1:0] idx;
    logic            found;
    int              ofs;

    always_comb begin
        rot   = '0;
        idx   = '0;
        found = 1'b0;
        ofs   = 0;
        // rot[0] is the requester just after last
        for (int i = 0; i < NREQ; i++) begin
            idx    = IDXW'((int'(last) + 1 + i) % NREQ);
            rot[i] = req[idx];
        end
        for (int i = 0; i < NREQ; i++) begin
            if (rot[i] && !found) begin
                found = 1'b1;
                ofs   = i;
            end
        end
        valid = found;
        pick  = IDXW'((int'(last) + 1 + ofs) % NREQ);
    end

endmodule

// File: rtl/trig_sched.sv
// trig_sched: shares one ena/trigger pulse unit between NREQ requesters.
//   clk, rst - clock, async active-high reset
//   bus      - slave side of trig_sched_if (req/trigger in; ena/grant/done/err/busy out)
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ena low, pick next requester round-robin when any req set
// ST_RUN  | ena high for owner until trigger, abort or timeout
// ST_GAP  | ena forced low for GAP cycles so the unit's count clears
module trig_sched
    import trig_sched_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int GAP     = GAP_DEF
) (
    input  logic         clk,
    input  logic         rst,
    trig_sched_if.slave  bus
);

    localparam int IDXW = clog2(NREQ);
    localparam int CNTW = clog2(TIMEOUT + 1);
    localparam int GAPW = clog2(GAP + 1);

    state_e          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [GAPW-1:0] gap_q, gap_d;
    logic [IDXW-1:0] last_q, last_d;
    logic            ena_q, ena_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [NREQ-1:0] err_q, err_d;
    logic            busy_q, busy_d;

    logic [IDXW-1:0] pick;
    logic            pick_valid;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (bus.req),
        .last  (last_q),
        .pick  (pick),
        .valid (pick_valid)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        last_d  = last_q;
        ena_d   = ena_q;
        grant_d = grant_q;
        done_d  = '0;
        err_d   = '0;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_RUN;
                    grant_d = NREQ'(1) << pick;
                    ena_d   = 1'b1;
                    cnt_d   = CNTW'(1);
                    last_d  = pick;
                end
            end
            ST_RUN: begin
                // trigger beats abort, abort beats timeout
                if (bus.trigger || !bus.req[last_q] || cnt_q == CNTW'(TIMEOUT)) begin
                    state_d = ST_GAP;
                    ena_d   = 1'b0;
                    grant_d = '0;
                    gap_d   = GAPW'(GAP);
                    if (bus.trigger)             done_d = grant_q;
                    else if (bus.req[last_q])    err_d  = grant_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_q == GAPW'(1)) state_d = ST_IDLE;
                else                   gap_d   = gap_q - 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                ena_d   = 1'b0;
                grant_d = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            last_q  <= IDXW'(NREQ - 1);
            ena_q   <= 1'b0;
            grant_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            last_q  <= last_d;
            ena_q   <= ena_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.ena   = ena_q;
    assign bus.grant = grant_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_trig_sched.sv
// tb_trig_sched: directed bench for trig_sched (NREQ=4, TIMEOUT=16, GAP=1).
module tb_trig_sched;
    import trig_sched_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   total  = 0;
    int   passed = 0;
    int   failed = 0;

    trig_sched_if #(.NREQ(4)) bus ();

    trig_sched #(.NREQ(4), .TIMEOUT(16), .GAP(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // wait for a grant, bounded; latency counted in negedges from call
    task automatic wait_grant(input string tag, input logic [3:0] exp, input int exp_lat);
        int lat;
        lat = 0;
        while (bus.grant == 4'b0 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_grant"}, 32'(bus.grant), 32'(exp));
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    endtask

    // called in the first ena cycle; trigger high in ena cycle n
    task automatic trig_after(input string tag, input int n);
        int hi;
        hi = 0;
        for (int i = 1; i <= n; i++) begin
            if (bus.ena === 1'b1) hi++;
            if (i == n) bus.trigger = 1'b1;
            @(negedge clk);
        end
        bus.trigger = 1'b0;
        check({tag, "_ena_cycles"}, 32'(hi), 32'(n));
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            check("inv_grant_iff_ena", 32'(bus.grant != 4'b0), 32'(bus.ena));
            check("done_err_excl", 32'((|bus.done) && (|bus.err)), 32'(0));
        end
    end

    logic [3:0] rr_exp [5];
    int n;

    initial begin
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;

        rst = 1'b1;
        bus.req = 4'b0;
        bus.trigger = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_ena",   32'(bus.ena),   32'(0));
        check("rst_grant", 32'(bus.grant), 32'(0));
        check("rst_done",  32'(bus.done),  32'(0));
        check("rst_err",   32'(bus.err),   32'(0));
        check("rst_busy",  32'(bus.busy),  32'(0));

        // trigger with no owner does nothing
        bus.trigger = 1'b1;
        repeat (3) @(negedge clk);
        bus.trigger = 1'b0;
        check("idle_trig_busy", 32'(bus.busy), 32'(0));
        check("idle_trig_done", 32'(bus.done), 32'(0));

        // single requester, triggered after 8 ena cycles
        bus.req = 4'b0001;
        wait_grant("single", 4'b0001, 1);
        check("single_busy", 32'(bus.busy), 32'(1));
        trig_after("single", 8);
        check("single_done",  32'(bus.done),  32'(4'b0001));
        check("single_ena",   32'(bus.ena),   32'(0));
        check("single_busy2", 32'(bus.busy),  32'(1));
        bus.req = 4'b0;
        @(negedge clk);
        check("single_done_pulse", 32'(bus.done), 32'(0));
        check("single_gap_end",    32'(bus.busy), 32'(0));

        // round robin from reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant($sformatf("rr%0d", k), rr_exp[k], (k == 0) ? 1 : 2);
            trig_after($sformatf("rr%0d", k), 3);
            check($sformatf("rr%0d_done", k), 32'(bus.done), 32'(rr_exp[k]));
        end
        bus.req = 4'b0;
        repeat (2) @(negedge clk);

        // timeout on requester 2
        bus.req = 4'b0100;
        wait_grant("tmo", 4'b0100, 1);
        n = 0;
        while (bus.ena === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("tmo_ena_cycles", 32'(n), 32'(16));
        check("tmo_err",  32'(bus.err),  32'(4'b0100));
        check("tmo_done", 32'(bus.done), 32'(0));
        wait_grant("tmo_regrant", 4'b0100, 2);

        // trigger in the timeout cycle wins
        trig_after("simul", 16);
        check("simul_done", 32'(bus.done), 32'(4'b0100));
        check("simul_err",  32'(bus.err),  32'(0));
        bus.req = 4'b0;
        repeat (2) @(negedge clk);

        // abort by requester 1 with requester 3 pending
        bus.req = 4'b0010;
        wait_grant("abort", 4'b0010, 1);
        bus.req = 4'b1010;
        repeat (3) @(negedge clk);
        bus.req = 4'b1000;
        @(negedge clk);
        check("abort_ena",   32'(bus.ena),   32'(0));
        check("abort_grant", 32'(bus.grant), 32'(0));
        check("abort_done",  32'(bus.done),  32'(0));
        check("abort_err",   32'(bus.err),   32'(0));
        wait_grant("abort_next", 4'b1000, 2);

        // async reset mid-RUN
        rst = 1'b1;
        #1;
        check("arst_ena",   32'(bus.ena),   32'(0));
        check("arst_grant", 32'(bus.grant), 32'(0));
        check("arst_busy",  32'(bus.busy),  32'(0));
        bus.req = 4'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
